// File: rtl/spi_shift_xcvr.sv
// Full-duplex SPI shift engine: serialises a parallel word MSB- or LSB-first on
// each ena strobe while capturing the same number of bits from SerIn.
module spi_shift_xcvr #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] DatIn,
    input  logic             SerIn,
    output logic             DatOut,
    output logic [WIDTH-1:0] RxData,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted_s;
    logic             tx_bit_s;

    // Shift direction and the bit currently presented on the line
    always_comb begin
        if (MSB_FIRST) begin
            shifted_s = {shreg_q[WIDTH-2:0], SerIn};
            tx_bit_s  = shreg_q[WIDTH-1];
        end else begin
            shifted_s = {SerIn, shreg_q[WIDTH-1:1]};
            tx_bit_s  = shreg_q[0];
        end
    end

    // Next-state logic for the transfer FSM and its datapath registers
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // load wins over ena; ena has no meaning until the word is in shreg
                if (load) begin
                    shreg_d = DatIn;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ena) begin
                    shreg_d = shifted_s;
                    if (cnt_q == CNT_LAST) begin
                        rx_d    = shifted_s;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end else begin
                    shreg_d = shreg_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            rx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign DatOut = (state_q == ST_SHIFT) ? tx_bit_s : IDLE_LEVEL;
    assign RxData = rx_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_spi_shift_xcvr.sv
// Scoreboard bench: stimulus queues expected MOSI bits and RxData words, and
// negedge monitors compare them against two DUT configurations.
module tb_spi_shift_xcvr;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT A: WIDTH=8, MSB first
    logic       a_ena, a_load, a_ser, a_loop, a_serin, a_dout, a_busy, a_done;
    logic [7:0] a_din, a_rx;
    assign a_serin = a_loop ? a_dout : a_ser;

    spi_shift_xcvr #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst), .ena(a_ena), .load(a_load), .DatIn(a_din),
        .SerIn(a_serin), .DatOut(a_dout), .RxData(a_rx), .busy(a_busy), .done(a_done)
    );

    // DUT B: WIDTH=12, LSB first
    logic        b_ena, b_load, b_ser, b_loop, b_serin, b_dout, b_busy, b_done;
    logic [11:0] b_din, b_rx;
    assign b_serin = b_loop ? b_dout : b_ser;

    spi_shift_xcvr #(.WIDTH(12), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .rst(rst), .ena(b_ena), .load(b_load), .DatIn(b_din),
        .SerIn(b_serin), .DatOut(b_dout), .RxData(b_rx), .busy(b_busy), .done(b_done)
    );

    int n_vec = 0;
    int n_err = 0;

    logic        a_bitq[$];
    logic [7:0]  a_rxq[$];
    logic        b_bitq[$];
    logic [11:0] b_rxq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor A: every busy cycle DatOut must equal the head bit; a strobe retires it
    always @(negedge clk) begin
        if (!rst) begin
            if (a_busy) begin
                if (a_bitq.size() == 0) begin
                    check("a_bitq_underflow", 32'd1, 32'd0);
                end else begin
                    check("a_dout", {31'd0, a_dout}, {31'd0, a_bitq[0]});
                    if (a_ena) void'(a_bitq.pop_front());
                end
            end else begin
                check("a_dout_idle", {31'd0, a_dout}, 32'd0);
            end
            if (a_done) begin
                if (a_rxq.size() == 0) check("a_rxq_underflow", 32'd1, 32'd0);
                else check("a_rxdata", {24'd0, a_rx}, {24'd0, a_rxq.pop_front()});
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst) begin
            if (b_busy) begin
                if (b_bitq.size() == 0) begin
                    check("b_bitq_underflow", 32'd1, 32'd0);
                end else begin
                    check("b_dout", {31'd0, b_dout}, {31'd0, b_bitq[0]});
                    if (b_ena) void'(b_bitq.pop_front());
                end
            end else begin
                check("b_dout_idle", {31'd0, b_dout}, 32'd0);
            end
            if (b_done) begin
                if (b_rxq.size() == 0) check("b_rxq_underflow", 32'd1, 32'd0);
                else check("b_rxdata", {20'd0, b_rx}, {20'd0, b_rxq.pop_front()});
            end
        end
    end

    task automatic a_start(input logic [7:0] din, input logic [7:0] rx_exp, input bit push_rx);
        for (int i = 7; i >= 0; i--) a_bitq.push_back(din[i]);
        if (push_rx) a_rxq.push_back(rx_exp);
        a_din  = din;
        a_load = 1'b1;
        @(posedge clk); #1;
        a_load = 1'b0;
        check("a_busy_after_load", {31'd0, a_busy}, 32'd1);
        check("a_done_after_load", {31'd0, a_done}, 32'd0);
    endtask

    // n strobes, one every 'period' cycles; 'last' marks the final strobe of a word
    task automatic a_strobes(input int n, input int period, input bit last);
        for (int s = 0; s < n; s++) begin
            for (int g = 1; g < period; g++) begin
                a_ena = 1'b0;
                @(posedge clk); #1;
                check("a_busy_gap", {31'd0, a_busy}, 32'd1);
                check("a_done_gap", {31'd0, a_done}, 32'd0);
            end
            a_ena = 1'b1;
            @(posedge clk); #1;
            a_ena = 1'b0;
            check("a_done_strobe", {31'd0, a_done}, {31'd0, (last && s == n - 1)});
            check("a_busy_strobe", {31'd0, a_busy}, {31'd0, !(last && s == n - 1)});
        end
    endtask

    task automatic b_xfer(input logic [11:0] din, input logic [11:0] ser_pat, input logic [11:0] rx_exp);
        for (int i = 0; i < 12; i++) b_bitq.push_back(din[i]);
        b_rxq.push_back(rx_exp);
        b_din  = din;
        b_load = 1'b1;
        @(posedge clk); #1;
        b_load = 1'b0;
        check("b_busy_after_load", {31'd0, b_busy}, 32'd1);
        for (int i = 0; i < 12; i++) begin
            b_ser = ser_pat[i];
            b_ena = 1'b1;
            @(posedge clk); #1;
            check("b_done_strobe", {31'd0, b_done}, {31'd0, (i == 11)});
        end
        b_ena = 1'b0;
        @(posedge clk); #1;
        check("b_done_clear", {31'd0, b_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_ena = 1'b0; a_load = 1'b0; a_ser = 1'b0; a_loop = 1'b1; a_din = 8'h00;
        b_ena = 1'b0; b_load = 1'b0; b_ser = 1'b0; b_loop = 1'b0; b_din = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_busy", {31'd0, a_busy}, 32'd0);
        check("rst_a_done", {31'd0, a_done}, 32'd0);
        check("rst_a_dout", {31'd0, a_dout}, 32'd0);
        check("rst_a_rx",   {24'd0, a_rx},   32'd0);
        check("rst_b_dout", {31'd0, b_dout}, 32'd0);
        check("rst_b_rx",   {20'd0, b_rx},   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Abort by reset after 4 strobes; reset also outranks load and ena
        a_start(8'hFF, 8'h00, 1'b0);
        a_strobes(4, 1, 1'b0);
        rst = 1'b1; a_ena = 1'b1; a_load = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; a_ena = 1'b0; a_load = 1'b0;
        check("abort_busy", {31'd0, a_busy}, 32'd0);
        check("abort_dout", {31'd0, a_dout}, 32'd0);
        check("abort_done", {31'd0, a_done}, 32'd0);
        check("abort_rx",   {24'd0, a_rx},   32'd0);
        check("abort_left", a_bitq.size(), 32'd4);
        a_bitq.delete();
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, a_done}, 32'd0);
        end

        // Loopback 8'hB9 with ena held high
        a_start(8'hB9, 8'hB9, 1'b1);
        a_strobes(8, 1, 1'b1);
        @(posedge clk); #1;
        check("b9_done_one_cycle", {31'd0, a_done}, 32'd0);
        check("b9_dout_idle", {31'd0, a_dout}, 32'd0);
        check("b9_rx_hold", {24'd0, a_rx}, 32'h0000_00B9);

        // ena every third cycle, loopback 8'h96
        a_start(8'h96, 8'h96, 1'b1);
        a_strobes(8, 3, 1'b1);
        @(posedge clk); #1;

        // load of 8'h00 after 3 strobes of 8'hFF is ignored
        a_start(8'hFF, 8'hFF, 1'b1);
        a_strobes(3, 1, 1'b0);
        a_din = 8'h00; a_load = 1'b1;
        a_strobes(1, 1, 1'b0);
        a_load = 1'b0;
        a_strobes(4, 1, 1'b1);
        @(posedge clk); #1;

        // Back-to-back: load 8'h3C in the done cycle of 8'hB9
        a_start(8'hB9, 8'hB9, 1'b1);
        a_strobes(8, 1, 1'b1);
        a_start(8'h3C, 8'h3C, 1'b1);
        a_strobes(8, 1, 1'b1);
        @(posedge clk); #1;

        // LSB first, 12 bits, driven SerIn
        b_xfer(12'hA53, 12'h803, 12'h803);
        check("b_rx_hold", {20'd0, b_rx}, 32'h0000_0803);
        // LSB first loopback
        b_loop = 1'b1;
        b_xfer(12'h5C6, 12'h000, 12'h5C6);

        repeat (3) @(posedge clk);
        #1;
        check("a_bitq_empty", a_bitq.size(), 32'd0);
        check("a_rxq_empty",  a_rxq.size(),  32'd0);
        check("b_bitq_empty", b_bitq.size(), 32'd0);
        check("b_rxq_empty",  b_rxq.size(),  32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
